// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, error codes and FSM states.
package lsu_pkg;

    localparam int LSU_DW = 32;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and lane replication, load lane select and extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]        offset,
    input  logic [1:0]        size,
    input  logic              sgn,
    input  logic [LSU_DW-1:0] wdata_in,
    input  logic [LSU_DW-1:0] rdata_in,
    output logic [3:0]        byte_en,
    output logic [LSU_DW-1:0] wdata_out,
    output logic [LSU_DW-1:0] rdata_out
);

    logic [7:0]  lane8;
    logic [15:0] lane16;

    always_comb begin
        byte_en   = 4'b1111;
        wdata_out = wdata_in;
        rdata_out = rdata_in;
        lane8     = rdata_in[{offset, 3'b000} +: 8];
        lane16    = offset[1] ? rdata_in[31:16] : rdata_in[15:0];
        case (size)
            SIZE_BYTE: begin
                byte_en   = 4'b0001 << offset;
                wdata_out = {4{wdata_in[7:0]}};
                rdata_out = {{24{sgn & lane8[7]}}, lane8};
            end
            SIZE_HALF: begin
                byte_en   = offset[1] ? 4'b1100 : 4'b0011;
                wdata_out = {2{wdata_in[15:0]}};
                rdata_out = {{16{sgn & lane16[15]}}, lane16};
            end
            default: begin
                // Size code 3 behaves as a full word.
                byte_en   = 4'b1111;
                wdata_out = wdata_in;
                rdata_out = rdata_in;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time between execute and RAM port A,
// with address checking, byte-lane steering and a 1-cycle synchronous read.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int DATA_BYTES = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic [1:0]            resp_err,
    output logic [DATA_BYTES-1:0] ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    lsu_state_t state_q, state_d;
    logic [1:0]            off_q, off_d;
    logic [1:0]            size_q, size_d;
    logic                  sgn_q, sgn_d;
    logic [1:0]            err_q, err_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic       accept;
    logic       misalign;
    logic       out_of_range;
    logic [1:0] req_err;

    logic [1:0]            al_off;
    logic [1:0]            al_size;
    logic                  al_sgn;
    logic [3:0]            al_be;
    logic [DATA_WIDTH-1:0] al_wdata;
    logic [DATA_WIDTH-1:0] al_rdata;

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid & req_ready;

    assign misalign     = ((req_size == SIZE_HALF) && req_addr[0]) ||
                          (req_size[1] && (req_addr[1:0] != 2'b00));
    assign out_of_range = |req_addr[31:ADDR_WIDTH+2];
    assign req_err      = misalign ? ERR_MISALIGN : (out_of_range ? ERR_RANGE : ERR_NONE);

    // One aligner serves both directions: request fields while idle, latched load fields in READ.
    assign al_off  = (state_q == ST_READ) ? off_q  : req_addr[1:0];
    assign al_size = (state_q == ST_READ) ? size_q : req_size;
    assign al_sgn  = (state_q == ST_READ) ? sgn_q  : req_signed;

    lsu_align u_align (
        .offset    (al_off),
        .size      (al_size),
        .sgn       (al_sgn),
        .wdata_in  (req_wdata),
        .rdata_in  (ram_rdata),
        .byte_en   (al_be),
        .wdata_out (al_wdata),
        .rdata_out (al_rdata)
    );

    assign ram_addr   = (state_q == ST_READ) ? raddr_q : req_addr[ADDR_WIDTH+1:2];
    assign ram_wdata  = al_wdata;
    assign ram_we     = (accept && req_we && (req_err == ERR_NONE) && !rst) ? al_be : '0;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        err_d   = err_q;
        raddr_d = raddr_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err != ERR_NONE || req_we) begin
                        state_d = ST_RESP;
                        err_d   = req_err;
                        rdata_d = '0;
                    end else begin
                        state_d = ST_READ;
                        off_d   = req_addr[1:0];
                        size_d  = req_size;
                        sgn_d   = req_signed;
                        raddr_d = req_addr[ADDR_WIDTH+1:2];
                        err_d   = ERR_NONE;
                    end
                end
            end
            ST_READ: begin
                state_d = ST_RESP;
                rdata_d = al_rdata;
                err_d   = ERR_NONE;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            off_q   <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            err_q   <= ERR_NONE;
            raddr_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            err_q   <= err_d;
            raddr_q <= raddr_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu against a byte-addressed memory model.
module tb_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [3:0]  ram_we;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  lsu #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DATA_BYTES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // Clock / reset and RAM port A model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:511];

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (ram_we[k]) mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
    ram_rdata <= mem[ram_addr];
  end

  // Reference model: flat byte memory
  logic [7:0]  ref_mem [0:2047];
  logic [31:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
  endfunction

  function automatic logic [1:0] exp_err(input logic [1:0] size, input logic [31:0] addr);
    int n;
    n = nbytes(size);
    if ((n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00)) return 2'd1;
    if (addr >= 32'd2048) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] load_val(input logic [1:0] size, input logic sgn, input logic [31:0] addr);
    int n;
    logic [31:0] v;
    n = nbytes(size);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[addr[10:0] + 11'(i)]) << (8 * i));
    if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  // Driver: one complete transaction, checking the RAM side and the response.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    int n;
    int lat;
    logic [1:0]  e;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    n = nbytes(size);
    e = exp_err(size, addr);
    be = 4'b0000;
    for (int i = 0; i < n; i++) be[int'(addr[1:0]) + i] = 1'b1;
    for (int k = 0; k < 4; k++) wd[8*k +: 8] = wdata[8*(k % n) +: 8];
    exp_q.push_back((!we && e == 2'd0) ? load_val(size, sgn, addr) : 32'h0);

    check("idle_ready", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = (hold == 0);
    #1;
    check("ram_we", 32'(ram_we), (we && e == 2'd0) ? 32'(be) : 32'd0);
    if (e == 2'd0) check("ram_addr", 32'(ram_addr), 32'(addr[10:2]));
    if (we && e == 2'd0) check("ram_wdata", ram_wdata, wd);
    @(posedge clk); #1;
    if (we && e == 2'd0)
      for (int i = 0; i < n; i++) ref_mem[addr[10:0] + 11'(i)] = wdata[8*i +: 8];

    // Garbage requests while busy must be ignored.
    req_valid = 1'(($urandom_range(0, 1)));
    req_we    = 1'b1;
    req_size  = 2'd2;
    req_addr  = $urandom & 32'h0000_07FC;
    req_wdata = $urandom;

    lat = 1;
    while (!resp_valid && lat < 6) begin
      check("busy_we", 32'(ram_we), 32'd0);
      check("busy_ready", 32'(req_ready), 32'd0);
      if (!we && e == 2'd0) check("read_addr", 32'(ram_addr), 32'(addr[10:2]));
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), (we || e != 2'd0) ? 32'd1 : 32'd2);

    exp_rd = exp_q.pop_front();
    for (int h = 0; h <= hold; h++) begin
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_rdata", resp_rdata, exp_rd);
      check("resp_err", 32'(resp_err), 32'(e));
      check("resp_we", 32'(ram_we), 32'd0);
      if (h > 0) check("hold_ready", 32'(req_ready), 32'd0);
      if (h == hold) begin
        req_valid  = 1'b0;
        resp_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("back_idle", 32'(req_ready), 32'd1);
    check("resp_drop", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] a;
    logic [1:0]  sz;
    int r;
    for (int i = 0; i < 512; i++) begin
      w = $urandom;
      mem[i] <= w;
      for (int k = 0; k < 4; k++) ref_mem[i*4 + k] = w[8*k +: 8];
    end

    rst        = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_size   = 2'd2;
    req_signed = 1'b0;
    req_addr   = 32'h40;
    req_wdata  = 32'h0BAD_F00D;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    check("plan_word", load_val(2'd2, 1'b0, 32'h10), 32'hDEAD_BEEF);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 0);
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, 0);
    do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_005A, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 0);
    do_req(1'b1, 2'd1, 1'b0, 32'h801, 32'h1234, 0);
    do_req(1'b1, 2'd2, 1'b0, 32'h800, 32'h5555_AAAA, 0);
    do_req(1'b0, 2'd3, 1'b1, 32'h20, 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);

    // Reset while a load sits in READ: no response, unit idle afterwards.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_size   = 2'd2;
    req_signed = 1'b0;
    req_addr   = 32'h10;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_busy", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("post_rst_valid", 32'(resp_valid), 32'd0);
      check("post_rst_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      r  = $urandom_range(0, 9);
      sz = 2'($urandom_range(0, 3));
      if (r == 0) a = $urandom;
      else a = 32'($urandom_range(0, 2047));
      if (r < 8) begin
        if (sz == 2'd1) a[0] = 1'b0;
        else if (sz[1]) a[1:0] = 2'b00;
      end
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
             ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
